// File: rtl/pc_fetch_unit.sv
// Fetch stage for the unpipelined MIPS32 core: holds the PC, fetches over req/ack, and picks the next PC on retire.
// Optional interrupt-take support is enabled by defining PC_FETCH_IRQ_EN.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR    = 32'h0000_0180,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr,
    output logic        o_instr_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    input  logic        i_stall,
    input  logic        i_beq,
    input  logic        i_bne,
    input  logic        i_j,
    input  logic        i_jr,
    input  logic        i_eret,
    input  logic        i_zero,
    input  logic [31:0] i_jr_target,
    input  logic [31:0] i_epc,
`ifdef PC_FETCH_IRQ_EN
    input  logic        i_irq,
    output logic        o_exc_take,
    output logic [31:0] o_exc_epc,
`endif
    output logic        o_fetch_err
);

    localparam int CNT_W = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, ERR} state_t;

    state_t           state, state_d;
    logic [31:0]      pc, pc_d;
    logic [31:0]      instr_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [31:0]      pc_plus4;
    logic [31:0]      br_target;
    logic [31:0]      flow_pc;
    logic             retire;
    logic             irq_take;

    assign pc_plus4    = pc + 32'd4;
    assign br_target   = pc_plus4 + {{14{o_instr[15]}}, o_instr[15:0], 2'b00};
    assign o_pc        = pc;
    assign o_pc_plus4  = pc_plus4;
    assign o_imem_addr = pc;

`ifdef PC_FETCH_IRQ_EN
    assign irq_take = i_irq;
`else
    assign irq_take = 1'b0;
`endif

    // Architectural next PC from the decoder controls, highest priority first.
    always_comb begin
        flow_pc = pc_plus4;
        if (i_eret)
            flow_pc = i_epc;
        else if (i_jr)
            flow_pc = i_jr_target;
        else if (i_j)
            flow_pc = {pc_plus4[31:28], o_instr[25:0], 2'b00};
        else if ((i_beq && i_zero) || (i_bne && !i_zero))
            flow_pc = br_target;
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d       = state;
        pc_d          = pc;
        instr_d       = o_instr;
        cnt_d         = cnt;
        o_imem_req    = 1'b0;
        o_instr_valid = 1'b0;
        o_fetch_err   = 1'b0;
        retire        = 1'b0;
        case (state)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (pc[1:0] != 2'b00) begin
                    cnt_d   = '0;
                    state_d = ERR;
                end else begin
                    o_imem_req = 1'b1;
                    if (i_imem_ack) begin
                        instr_d = i_imem_rdata;
                        cnt_d   = '0;
                        state_d = EXEC;
                    end else if (cnt == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ERR;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
            end
            ERR: begin
                o_fetch_err = 1'b1;
                pc_d        = EXC_VECTOR;
                state_d     = FETCH;
            end
            EXEC: begin
                o_instr_valid = 1'b1;
                if (!i_stall) begin
                    retire  = 1'b1;
                    pc_d    = irq_take ? EXC_VECTOR : flow_pc;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            o_instr <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_d;
            pc      <= pc_d;
            o_instr <= instr_d;
            cnt     <= cnt_d;
        end
    end

`ifdef PC_FETCH_IRQ_EN
    // EPC capture holds the PC the interrupted flow would have continued at.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_exc_take <= 1'b0;
            o_exc_epc  <= '0;
        end else begin
            o_exc_take <= retire && i_irq;
            if (retire && i_irq)
                o_exc_epc <= flow_pc;
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: reset, sequential/branch/jump flow, misalignment, timeout, stall and PC wrap.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        stall = 1'b0;
    logic        beq = 1'b0, bne = 1'b0, j = 1'b0, jr = 1'b0, eret = 1'b0, zero = 1'b0;
    logic [31:0] jr_target = '0;
    logic [31:0] epc = '0;
    logic        fetch_err;
`ifdef PC_FETCH_IRQ_EN
    logic        irq = 1'b0;
    logic        exc_take;
    logic [31:0] exc_epc;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    pc_fetch_unit dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .o_imem_req   (imem_req),
        .o_imem_addr  (imem_addr),
        .i_imem_ack   (imem_ack),
        .i_imem_rdata (imem_rdata),
        .o_instr      (instr),
        .o_instr_valid(instr_valid),
        .o_pc         (pc),
        .o_pc_plus4   (pc_plus4),
        .i_stall      (stall),
        .i_beq        (beq),
        .i_bne        (bne),
        .i_j          (j),
        .i_jr         (jr),
        .i_eret       (eret),
        .i_zero       (zero),
        .i_jr_target  (jr_target),
        .i_epc        (epc),
`ifdef PC_FETCH_IRQ_EN
        .i_irq        (irq),
        .o_exc_take   (exc_take),
        .o_exc_epc    (exc_epc),
`endif
        .o_fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    task automatic clear_ctl();
        beq = 1'b0; bne = 1'b0; j = 1'b0; jr = 1'b0; eret = 1'b0; zero = 1'b0;
        stall = 1'b0;
    endtask

    // Bounded wait for a request, then check the address and ack it once.
    task automatic fetch_exec(input string tag, input logic [31:0] addr, input logic [31:0] data);
        int n = 0;
        while (!imem_req && n < 8) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req"}, 32'(imem_req), 32'd1);
        check({tag, "_addr"}, imem_addr, addr);
        imem_ack   = 1'b1;
        imem_rdata = data;
        @(negedge clk);
        imem_ack = 1'b0;
        check({tag, "_valid"}, 32'(instr_valid), 32'd1);
        check({tag, "_instr"}, instr, data);
        check({tag, "_pc"}, pc, addr);
    endtask

    task automatic retire_now();
        stall = 1'b0;
        @(negedge clk);
        clear_ctl();
    endtask

    initial begin
        logic [31:0] after_eret;
        int n;

        // Reset with a stray ack that must be ignored.
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_err", 32'(fetch_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_instr", instr, 32'h0);
        check("t1_req", 32'(imem_req), 32'd1);
        check("t1_addr", imem_addr, 32'h0);
        check("t1_nvalid", 32'(instr_valid), 32'd0);
        imem_rdata = 32'h2008_0005;
        @(negedge clk);
        imem_ack = 1'b0;
        check("t1_valid", 32'(instr_valid), 32'd1);
        check("t1_instr", instr, 32'h2008_0005);
        check("t1_plus4", pc_plus4, 32'h4);
        retire_now();

        // j to 0x100, then beq taken back to itself, then not taken.
        fetch_exec("seq4", 32'h4, 32'h0800_0040);
        j = 1'b1;
        retire_now();
        fetch_exec("beq_t", 32'h100, 32'h1000_FFFF);
        beq = 1'b1; zero = 1'b1;
        retire_now();
        fetch_exec("beq_t2", 32'h100, 32'h1000_FFFF);
        beq = 1'b1; zero = 1'b0;
        retire_now();
        fetch_exec("beq_nt", 32'h104, 32'h0300_0008);
        jr = 1'b1; jr_target = 32'h1000_0000;
        retire_now();
        fetch_exec("j_hi", 32'h1000_0000, 32'h0800_0040);
        j = 1'b1;
        retire_now();

        // jr to a misaligned target: no request, error pulse, vector fetch.
        fetch_exec("jr_mis", 32'h1000_0100, 32'h0300_0008);
        jr = 1'b1; jr_target = 32'h0000_0202;
        retire_now();
        check("mis_pc", pc, 32'h0000_0202);
        check("mis_noreq", 32'(imem_req), 32'd0);
        @(negedge clk);
        check("mis_err", 32'(fetch_err), 32'd1);
        check("mis_err_noreq", 32'(imem_req), 32'd0);
        @(negedge clk);
        check("mis_err_end", 32'(fetch_err), 32'd0);
        check("mis_vec", imem_addr, 32'h180);

        // Timeout: 16 request cycles without ack, then an error pulse.
        n = 0;
        while (imem_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("to_cycles", 32'(n), 32'd16);
        check("to_err", 32'(fetch_err), 32'd1);
        @(negedge clk);

        // Stalled eret: state held for 3 cycles, then redirect on release.
        fetch_exec("eret", 32'h180, 32'h4200_0018);
        stall = 1'b1; eret = 1'b1; epc = 32'h400;
`ifdef PC_FETCH_IRQ_EN
        irq = 1'b1;
`endif
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_pc", pc, 32'h180);
            check("stall_instr", instr, 32'h4200_0018);
        end
        retire_now();
`ifdef PC_FETCH_IRQ_EN
        irq = 1'b0;
        check("irq_take", 32'(exc_take), 32'd1);
        check("irq_epc", exc_epc, 32'h400);
        after_eret = 32'h180;
`else
        after_eret = 32'h400;
`endif
        check("eret_next", imem_addr, after_eret);

        // Wrap: 0xFFFF_FFFC + 4 = 0.
        fetch_exec("to_top", after_eret, 32'h0300_0008);
        jr = 1'b1; jr_target = 32'hFFFF_FFFC;
        retire_now();
        fetch_exec("top", 32'hFFFF_FFFC, 32'h0000_0000);
        check("wrap_plus4", pc_plus4, 32'h0);
        retire_now();

        // Ack in the final timeout cycle wins over the error.
        check("wrap_addr", imem_addr, 32'h0);
        repeat (15) @(negedge clk);
        check("late_req", 32'(imem_req), 32'd1);
        check("late_noerr", 32'(fetch_err), 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_1234;
        @(negedge clk);
        imem_ack = 1'b0;
        check("late_valid", 32'(instr_valid), 32'd1);
        check("late_instr", instr, 32'h0000_1234);
        check("late_noerr2", 32'(fetch_err), 32'd0);
        retire_now();
        check("late_next", imem_addr, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
